addsub_sat_pipe: RTL and testbench

- Parametrised, two-stage pipelined, saturating two's-complement adder/subtractor.
- Built from carry-lookahead groups, with a valid/ready handshake on both sides and a sticky overflow flag.
- Successor to the 16-bit combinational add/sub unit: generalises width, adds pipelining, backpressure and overflow accumulation.
- Sits between the register-read stage and the writeback mux in the ALU path.

---
 rtl/addsub_pkg.sv | 24 ++
 rtl/cla_group.sv | 57 +++++
 rtl/addsub_sat_pipe.sv | 179 +++++++++++++++++
 tb/tb_addsub_sat_pipe.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// Shared definitions for the pipelined saturating adder/subtractor.
//
// Contents:
//   OP_ADD / OP_SUB  encoding of the 'sub' operation select
//   MAX_WIDTH        widest operand the saturation helpers can describe
//   sat_max(width)   most-positive two's-complement value of 'width' bits
//   sat_min(width)   most-negative two's-complement value of 'width' bits
package addsub_pkg;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   localparam int MAX_WIDTH = 64;

   // Returned zero-extended to MAX_WIDTH; callers truncate to their width.
   function automatic logic [MAX_WIDTH-1:0] sat_max(input int width);
      return (MAX_WIDTH'(1) << (width - 1)) - MAX_WIDTH'(1);
   endfunction

   function automatic logic [MAX_WIDTH-1:0] sat_min(input int width);
      return MAX_WIDTH'(1) << (width - 1);
   endfunction

endpackage

// File: rtl/cla_group.sv
// One carry-lookahead group of G bits.
//
// Ports:
//   a, b  [G-1:0]  operand bits of this group
//   cin            carry into bit 0 of the group
//   sum   [G-1:0]  sum bits
//   gp             group propagate (all bits propagate)
//   gg             group generate (group produces a carry on its own)
//
// The carry out of the group is formed by the parent as gg | (gp & cin),
// which lets the parent chain groups on group P/G terms only.
module cla_group #(
   parameter int G = 4
) (
   input  logic [G-1:0] a,
   input  logic [G-1:0] b,
   input  logic         cin,
   output logic [G-1:0] sum,
   output logic         gp,
   output logic         gg
);

   logic [G-1:0] p;
   logic [G-1:0] g;
   logic [G-1:0] c;

   assign p = a ^ b;
   assign g = a & b;

   // Carry into bit n written as a flat sum of products:
   //   ci & p[0..n-1]  |  OR_j ( g[j] & p[j+1..n-1] )
   function automatic logic carry_into(input logic [G-1:0] pv,
                                       input logic [G-1:0] gv,
                                       input logic         ci,
                                       input int           n);
      logic cr;
      logic t;
      cr = ci;
      for (int j = 0; j < n; j++) cr = cr & pv[j];
      for (int j = 0; j < n; j++) begin
         t = gv[j];
         for (int k = j + 1; k < n; k++) t = t & pv[k];
         cr = cr | t;
      end
      return cr;
   endfunction

   always_comb begin
      c = '0;
      for (int i = 0; i < G; i++) c[i] = carry_into(p, g, cin, i);
   end

   assign sum = p ^ c;
   assign gp  = &p;
   assign gg  = carry_into(p, g, 1'b0, G);

endmodule

// File: rtl/addsub_sat_pipe.sv
// Two-stage pipelined, saturating two's-complement adder/subtractor.
// Stage 1 adds the low half, stage 2 the high half using the registered
// mid carry; both halves are built from chained cla_group instances.
//
// Optional feature (macro ADDSUB_SAT_EN):
//   defined   - an overflowing result is clamped to the most-positive or
//               most-negative value according to the sign of A
//   undefined - Sum is always the wrapped modulo-2^WIDTH result
//   Ovfl, ovfl_sticky, latency and handshake are identical in both builds.
//
// Ports:
//   clk, rst         clock; synchronous active-high reset
//   in_valid/ready   operand handshake (in_ready is combinational)
//   A, B  [WIDTH]    signed operands
//   sub              0 = A+B, 1 = A-B
//   out_valid/ready  result handshake
//   Sum   [WIDTH]    result, registered
//   Ovfl             signed overflow for the presented result
//   ovfl_sticky      set by every handed-off overflow result
//   sticky_clr       clears ovfl_sticky (a simultaneous set wins)
//
// Handshake: a transfer happens on a rising edge where valid && ready.
// A stage accepts when it is empty or its contents leave this same cycle,
// so in_ready = !s1_valid || (!out_valid || out_ready); there is no skid
// buffer. A presented result is held stable until out_ready takes it.
//
// Parameters: WIDTH even, >= 8, <= 64; GROUP must divide WIDTH/2.
module addsub_sat_pipe
   import addsub_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int GROUP = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] Sum,
   output logic             Ovfl,
   output logic             ovfl_sticky,
   input  logic             sticky_clr
);

   localparam int HALF = WIDTH / 2;
   localparam int NG   = HALF / GROUP;

   typedef struct packed {
      logic [HALF-1:0] low_sum;
      logic [HALF-1:0] a_hi;
      logic [HALF-1:0] bx_hi;
      logic            c_mid;
      logic            a_msb;
      logic            valid;
   } s1_reg_t;

   s1_reg_t s1;

   logic s1_ready;
   logic s2_ready;

   assign s2_ready = !out_valid || out_ready;
   assign s1_ready = !s1.valid || s2_ready;
   assign in_ready = s1_ready;

   // ---------------- stage 1: operand conditioning and low half
   logic [WIDTH-1:0] bx;
   logic             cin;

   // Subtraction is A + ~B + 1.
   always_comb begin
      bx  = B;
      cin = 1'b0;
      case (sub)
         OP_ADD: begin bx = B;  cin = 1'b0; end
         OP_SUB: begin bx = ~B; cin = 1'b1; end
      endcase
   end

   logic [NG:0]     c_lo;
   logic [NG-1:0]   gp_lo;
   logic [NG-1:0]   gg_lo;
   logic [HALF-1:0] sum_lo;

   assign c_lo[0] = cin;

   for (genvar k = 0; k < NG; k++) begin : g_lo
      cla_group #(.G(GROUP)) u_cla (
         .a   (A[k*GROUP +: GROUP]),
         .b   (bx[k*GROUP +: GROUP]),
         .cin (c_lo[k]),
         .sum (sum_lo[k*GROUP +: GROUP]),
         .gp  (gp_lo[k]),
         .gg  (gg_lo[k])
      );
      assign c_lo[k+1] = gg_lo[k] | (gp_lo[k] & c_lo[k]);
   end

   // ---------------- stage 2: high half, overflow, saturation
   logic [NG:0]     c_hi;
   logic [NG-1:0]   gp_hi;
   logic [NG-1:0]   gg_hi;
   logic [HALF-1:0] sum_hi;

   assign c_hi[0] = s1.c_mid;

   for (genvar k = 0; k < NG; k++) begin : g_hi
      cla_group #(.G(GROUP)) u_cla (
         .a   (s1.a_hi[k*GROUP +: GROUP]),
         .b   (s1.bx_hi[k*GROUP +: GROUP]),
         .cin (c_hi[k]),
         .sum (sum_hi[k*GROUP +: GROUP]),
         .gp  (gp_hi[k]),
         .gg  (gg_hi[k])
      );
      assign c_hi[k+1] = gg_hi[k] | (gp_hi[k] & c_hi[k]);
   end

   logic [WIDTH-1:0] raw_sum;
   logic             c_into_msb;
   logic             ovfl_nxt;
   logic [WIDTH-1:0] sum_nxt;

   assign raw_sum    = {sum_hi, s1.low_sum};
   // A sum bit is a ^ b ^ carry_in, so the carry into the MSB is recovered
   // from the MSB sum and operand bits.
   assign c_into_msb = sum_hi[HALF-1] ^ s1.a_msb ^ s1.bx_hi[HALF-1];
   assign ovfl_nxt   = c_into_msb ^ c_hi[NG];

`ifdef ADDSUB_SAT_EN
   localparam logic [WIDTH-1:0] SAT_MAX = WIDTH'(sat_max(WIDTH));
   localparam logic [WIDTH-1:0] SAT_MIN = WIDTH'(sat_min(WIDTH));

   // Overflow only happens when both operands share A's sign, so A's sign
   // tells which rail was crossed.
   assign sum_nxt = ovfl_nxt ? (s1.a_msb ? SAT_MIN : SAT_MAX) : raw_sum;
`else
   assign sum_nxt = raw_sum;
`endif

   // ---------------- state
   always_ff @(posedge clk) begin
      if (rst) begin
         s1          <= '0;
         out_valid   <= 1'b0;
         Sum         <= '0;
         Ovfl        <= 1'b0;
         ovfl_sticky <= 1'b0;
      end else begin
         if (s1_ready) begin
            s1.valid <= in_valid;
            if (in_valid) begin
               s1.low_sum <= sum_lo;
               s1.a_hi    <= A[WIDTH-1:HALF];
               s1.bx_hi   <= bx[WIDTH-1:HALF];
               s1.c_mid   <= c_lo[NG];
               s1.a_msb   <= A[WIDTH-1];
            end
         end

         if (s2_ready) begin
            out_valid <= s1.valid;
            if (s1.valid) begin
               Sum  <= sum_nxt;
               Ovfl <= ovfl_nxt;
            end
         end

         // Set has priority over clear.
         if (out_valid && out_ready && Ovfl) ovfl_sticky <= 1'b1;
         else if (sticky_clr)                ovfl_sticky <= 1'b0;
      end
   end

endmodule

// File: tb/tb_addsub_sat_pipe.sv
// Bench for addsub_sat_pipe (WIDTH=16, GROUP=4). Builds with or without
// ADDSUB_SAT_EN; the reference model follows the same macro.
module tb_addsub_sat_pipe;

   localparam int W = 16;

   // ---------------- clock / reset
   logic clk;
   logic rst;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- DUT
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a_op;
   logic [W-1:0] b_op;
   logic         sub_op;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] sum_out;
   logic         ovfl_out;
   logic         ovfl_sticky;
   logic         sticky_clr;

   addsub_sat_pipe #(.WIDTH(W), .GROUP(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .A           (a_op),
      .B           (b_op),
      .sub         (sub_op),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .Sum         (sum_out),
      .Ovfl        (ovfl_out),
      .ovfl_sticky (ovfl_sticky),
      .sticky_clr  (sticky_clr)
   );

   // ---------------- bookkeeping
   int n_checks = 0;
   int n_fail   = 0;

   logic [W:0] exp_q[$];   // {ovfl, sum} in acceptance order
   int         acc_q[$];   // acceptance cycle, -1 when latency is not checked
   logic       exp_sticky = 1'b0;
   bit         mon_en     = 1'b0;
   bit         rand_on    = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: exact integer arithmetic, then range test.
   function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
      int         ra;
      int         rb;
      int         r;
      logic       ov;
      logic [W-1:0] res;
      ra  = $signed(a);
      rb  = $signed(b);
      r   = s ? (ra - rb) : (ra + rb);
      ov  = (r > 32767) || (r < -32768);
      res = r[W-1:0];
`ifdef ADDSUB_SAT_EN
      if (ov) res = (r > 0) ? 16'h7FFF : 16'h8000;
`endif
      return {ov, res};
   endfunction

   logic [W-1:0] corners [8] = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000,
                                 16'hFFFF, 16'h00FF, 16'h0100, 16'h7000};

   function automatic logic [W-1:0] pick();
      if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 7)];
      return W'($urandom);
   endfunction

   // ---------------- driver tasks
   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input bit lat);
      int waited;
      waited = 0;
      @(negedge clk);
      in_valid = 1'b1;
      a_op     = a;
      b_op     = b;
      sub_op   = s;
      #1;
      while (!in_ready && waited < 200) begin
         @(negedge clk);
         #1;
         waited++;
      end
      if (in_ready) begin
         exp_q.push_back(model(a, b, s));
         acc_q.push_back(lat ? cyc : -1);
      end else begin
         n_checks++;
         n_fail++;
         $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles", waited);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int w;
      w = 0;
      while (exp_q.size() != 0 && w < 400) begin
         @(negedge clk);
         w++;
      end
      check("drain", exp_q.size(), 0);
   endtask

   // ---------------- scoreboard monitor
   initial begin
      bit         seen;
      bit         ho;
      logic       eo;
      logic [W:0] e;
      seen = 1'b0;
      forever begin
         @(negedge clk);
         #2;
         if (mon_en) begin
            check("sticky", {31'b0, ovfl_sticky}, {31'b0, exp_sticky});
            if (rst) begin
               exp_q.delete();
               acc_q.delete();
               exp_sticky = 1'b0;
               seen       = 1'b0;
            end else begin
               ho = out_valid && out_ready;
               eo = 1'b0;
               if (out_valid) begin
                  if (exp_q.size() == 0) begin
                     check("stale_valid", {31'b0, out_valid}, 32'd0);
                  end else begin
                     e = exp_q[0];
                     check("sum",  {16'b0, sum_out},  {16'b0, e[W-1:0]});
                     check("ovfl", {31'b0, ovfl_out}, {31'b0, e[W]});
                     if (!seen && acc_q[0] >= 0) check("latency", 32'(cyc - acc_q[0]), 32'd2);
                     seen = 1'b1;
                     eo   = e[W];
                     if (ho) begin
                        void'(exp_q.pop_front());
                        void'(acc_q.pop_front());
                        seen = 1'b0;
                     end
                  end
               end
               if (ho && eo)        exp_sticky = 1'b1;
               else if (sticky_clr) exp_sticky = 1'b0;
            end
         end
      end
   end

   // ---------------- watchdog
   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus
   logic [W-1:0] da [9] = '{16'h7000, 16'h8000, 16'h8000, 16'h00FF, 16'h0100,
                            16'h0000, 16'h7FFF, 16'hFFFF, 16'h0F0F};
   logic [W-1:0] db [9] = '{16'h2000, 16'h0001, 16'h8000, 16'h0001, 16'h0001,
                            16'h8000, 16'h0001, 16'h0001, 16'h00F1};
   logic         ds [9] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

   initial begin
      int w;
      rst        = 1'b1;
      in_valid   = 1'b0;
      a_op       = '0;
      b_op       = '0;
      sub_op     = 1'b0;
      out_ready  = 1'b1;
      sticky_clr = 1'b0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      rst    = 1'b0;
      mon_en = 1'b1;
      #1;
      check("rst_in_ready",  {31'b0, in_ready},    32'd1);
      check("rst_out_valid", {31'b0, out_valid},   32'd0);
      check("rst_sum",       {16'b0, sum_out},     32'd0);
      check("rst_ovfl",      {31'b0, ovfl_out},    32'd0);
      check("rst_sticky",    {31'b0, ovfl_sticky}, 32'd0);

      // Directed boundary cases, back to back, latency checked.
      for (int i = 0; i < 9; i++) send(da[i], db[i], ds[i], 1'b1);
      wait_drain();
      @(negedge clk);
      #3;
      check("sticky_after_ovfl", {31'b0, ovfl_sticky}, 32'd1);

      // Clear with no handoff in flight.
      @(negedge clk);
      sticky_clr = 1'b1;
      @(negedge clk);
      sticky_clr = 1'b0;
      #3;
      check("sticky_cleared", {31'b0, ovfl_sticky}, 32'd0);

      // Backpressure: 4 ops while the consumer stalls for 5 cycles.
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      fork
         begin
            for (int i = 0; i < 4; i++) send(pick(), pick(), 1'(i), 1'b0);
         end
         begin
            repeat (3) @(negedge clk);
            #2;
            check("bp_in_ready_low", {31'b0, in_ready}, 32'd0);
         end
         begin
            repeat (5) @(negedge clk);
            out_ready = 1'b1;
         end
      join
      wait_drain();

      // Set wins over a simultaneous clear: sticky first set, then an
      // overflow handoff lands in the same cycle as sticky_clr.
      send(16'h7000, 16'h2000, 1'b0, 1'b1);
      wait_drain();
      @(negedge clk);
      out_ready = 1'b0;
      send(16'h8000, 16'h0001, 1'b1, 1'b0);
      w = 0;
      while (!out_valid && w < 20) begin
         @(negedge clk);
         #1;
         w++;
      end
      check("ovfl_presented", {31'b0, out_valid}, 32'd1);
      @(negedge clk);
      out_ready  = 1'b1;
      sticky_clr = 1'b1;
      @(negedge clk);
      sticky_clr = 1'b0;
      #3;
      check("sticky_set_wins", {31'b0, ovfl_sticky}, 32'd1);
      wait_drain();

      // Randomised traffic with random stalls and clears.
      rand_on = 1'b1;
      fork
         begin
            for (int i = 0; i < 300; i++) begin
               send(pick(), pick(), 1'($urandom_range(0, 1)), 1'b0);
               if ($urandom_range(0, 4) == 0) @(negedge clk);
            end
            rand_on = 1'b0;
         end
         begin
            while (rand_on) begin
               @(negedge clk);
               out_ready  = ($urandom_range(0, 3) != 0);
               sticky_clr = ($urandom_range(0, 7) == 0);
            end
            out_ready  = 1'b1;
            sticky_clr = 1'b0;
         end
      join
      wait_drain();

      // Reset with two operations in flight.
      send(16'h7000, 16'h2000, 1'b0, 1'b0);
      wait_drain();
      @(negedge clk);
      out_ready = 1'b0;
      send(16'h7000, 16'h2000, 1'b0, 1'b0);
      send(16'h8000, 16'h0001, 1'b1, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #3;
      check("inflight_rst_out_valid", {31'b0, out_valid},   32'd0);
      check("inflight_rst_sum",       {16'b0, sum_out},     32'd0);
      check("inflight_rst_ovfl",      {31'b0, ovfl_out},    32'd0);
      check("inflight_rst_sticky",    {31'b0, ovfl_sticky}, 32'd0);
      out_ready = 1'b1;
      repeat (10) @(negedge clk);

      // One more operation after reset to confirm the pipe restarts.
      send(16'h00FF, 16'h0001, 1'b0, 1'b1);
      wait_drain();
      repeat (2) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
